// File: rtl/nic_flit_tx.sv
`default_nettype none
// ============================================================================
// Module   : nic_flit_tx
// Purpose  : Node-side injection transmitter for one router input port.
//            Accepts flits from the network interface and drives them onto
//            the router's incoming channel. Keeps one private credit counter
//            per VC plus a shared-buffer credit pool, prefers private
//            credits, and flags shared-credit flits on shared_vc_out.
//            Tracks head/tail framing and raises a sticky error on framing
//            violations and on credit-return overflow.
// Ports    : clk                  - clock, rising edge
//            reset                - asynchronous, active-low reset
//            inj_valid/inj_ready  - injection handshake (ready is comb.)
//            inj_vc/head/tail/data- offered flit
//            channel_out          - {valid, vc, head, tail, data}, registered
//            shared_vc_out        - flit on channel_out used a shared credit
//            flow_ctrl_in         - {credit_valid, credit_vc} private return
//            credit_for_shared_in - shared credit return
//            idle                 - all credits home and no packet open
//            error                - sticky protocol / credit error
// Revision : 1.0 - initial release
// ============================================================================
module nic_flit_tx #(
    parameter int NUM_VCS         = 4,
    parameter int VC_IDX_WIDTH    = $clog2(NUM_VCS),
    parameter int VC_CREDITS      = 4,
    parameter int SHARED_CREDITS  = 8,
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int CHANNEL_WIDTH   = 1 + VC_IDX_WIDTH + 2 + FLIT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inj_valid,
    output logic                       inj_ready,
    input  logic [VC_IDX_WIDTH-1:0]    inj_vc,
    input  logic                       inj_head,
    input  logic                       inj_tail,
    input  logic [FLIT_DATA_WIDTH-1:0] inj_data,
    output logic [CHANNEL_WIDTH-1:0]   channel_out,
    output logic                       shared_vc_out,
    input  logic [VC_IDX_WIDTH:0]      flow_ctrl_in,
    input  logic                       credit_for_shared_in,
    output logic                       idle,
    output logic                       error
);

    localparam int c_PRIV_W = $clog2(VC_CREDITS + 1);
    localparam int c_SHR_W  = $clog2(SHARED_CREDITS + 1);

    localparam logic [c_PRIV_W-1:0] c_PRIV_MAX = c_PRIV_W'(VC_CREDITS);
    localparam logic [c_PRIV_W-1:0] c_PRIV_ONE = c_PRIV_W'(1);
    localparam logic [c_SHR_W-1:0]  c_SHR_MAX  = c_SHR_W'(SHARED_CREDITS);
    localparam logic [c_SHR_W-1:0]  c_SHR_ONE  = c_SHR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PRIV_W-1:0]      r_priv [NUM_VCS];
    logic [c_SHR_W-1:0]       r_shr;
    state_t                   r_state;
    logic [VC_IDX_WIDTH-1:0]  r_open_vc;
    logic [CHANNEL_WIDTH-1:0] r_channel;
    logic                     r_shared;
    logic                     r_error;

    // ------------------------------------------------------------------
    // Acceptance and credit selection
    // ------------------------------------------------------------------
    logic                     w_priv_avail;
    logic                     w_shr_avail;
    logic                     w_accept;
    logic                     w_use_priv;
    logic                     w_use_shr;
    logic                     w_ret_valid;
    logic [VC_IDX_WIDTH-1:0]  w_ret_vc;

    assign w_priv_avail = (r_priv[inj_vc] != '0);
    assign w_shr_avail  = (r_shr != '0);
    // Ready looks only at the registered counters, so a credit returned
    // this cycle cannot open the gate until the next cycle.
    assign inj_ready    = inj_valid & (w_priv_avail | w_shr_avail);
    assign w_accept     = inj_ready;
    assign w_use_priv   = w_accept & w_priv_avail;
    assign w_use_shr    = w_accept & ~w_priv_avail;
    assign w_ret_valid  = flow_ctrl_in[VC_IDX_WIDTH];
    assign w_ret_vc     = flow_ctrl_in[VC_IDX_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Private counter next-state
    // ------------------------------------------------------------------
    logic [NUM_VCS-1:0]  w_priv_cons;
    logic [NUM_VCS-1:0]  w_priv_ret;
    logic [c_PRIV_W-1:0] w_priv_nxt [NUM_VCS];
    logic                w_priv_ovf;

    always_comb begin
        w_priv_cons = '0;
        w_priv_ret  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_priv_cons[v] = w_use_priv  & (inj_vc   == VC_IDX_WIDTH'(v));
            w_priv_ret[v]  = w_ret_valid & (w_ret_vc == VC_IDX_WIDTH'(v));
        end
    end

    always_comb begin
        w_priv_nxt = r_priv;
        w_priv_ovf = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            // Consume and return on the same VC cancel out.
            if (w_priv_ret[v] && !w_priv_cons[v]) begin
                if (r_priv[v] == c_PRIV_MAX) begin
                    w_priv_ovf = 1'b1;
                end else begin
                    w_priv_nxt[v] = r_priv[v] + c_PRIV_ONE;
                end
            end else if (w_priv_cons[v] && !w_priv_ret[v]) begin
                w_priv_nxt[v] = r_priv[v] - c_PRIV_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared counter next-state
    // ------------------------------------------------------------------
    logic [c_SHR_W-1:0] w_shr_nxt;
    logic               w_shr_ovf;

    always_comb begin
        w_shr_nxt = r_shr;
        w_shr_ovf = 1'b0;
        if (credit_for_shared_in && !w_use_shr) begin
            if (r_shr == c_SHR_MAX) begin
                w_shr_ovf = 1'b1;
            end else begin
                w_shr_nxt = r_shr + c_SHR_ONE;
            end
        end else if (w_use_shr && !credit_for_shared_in) begin
            w_shr_nxt = r_shr - c_SHR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Framing checks
    // ------------------------------------------------------------------
    logic w_proto_err;

    assign w_proto_err = w_accept &
        (((r_state == ST_IDLE) & ~inj_head) |
         ((r_state == ST_OPEN) & (inj_head | (inj_vc != r_open_vc))));

    // ------------------------------------------------------------------
    // Registers and packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_priv[v] <= c_PRIV_MAX;
            end
            r_shr     <= c_SHR_MAX;
            r_state   <= ST_IDLE;
            r_open_vc <= '0;
            r_channel <= '0;
            r_shared  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_priv  <= w_priv_nxt;
            r_shr   <= w_shr_nxt;
            r_error <= r_error | w_priv_ovf | w_shr_ovf | w_proto_err;

            if (w_accept) begin
                r_channel <= {1'b1, inj_vc, inj_head, inj_tail, inj_data};
                r_shared  <= w_use_shr;
            end else begin
                r_channel <= '0;
                r_shared  <= 1'b0;
            end

            // Framing errors are flagged above; the FSM still follows the
            // head/tail bits so it resynchronises on the next packet.
            if (w_accept) begin
                if (inj_head) begin
                    r_state   <= inj_tail ? ST_IDLE : ST_OPEN;
                    r_open_vc <= inj_vc;
                end else if (inj_tail) begin
                    r_state   <= ST_IDLE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_all_priv_full;

    always_comb begin
        w_all_priv_full = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (r_priv[v] != c_PRIV_MAX) begin
                w_all_priv_full = 1'b0;
            end
        end
    end

    assign channel_out   = r_channel;
    assign shared_vc_out = r_shared;
    assign error         = r_error;
    assign idle          = (r_state == ST_IDLE) & w_all_priv_full & (r_shr == c_SHR_MAX);

endmodule
`default_nettype wire

// File: tb/tb_nic_flit_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_nic_flit_tx
// Purpose  : Self-checking bench for nic_flit_tx. A reference model of the
//            credit counters and packet framing predicts every accepted flit
//            and pushes it to a scoreboard; a monitor pops and compares as
//            flits appear on channel_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nic_flit_tx;

    localparam int NV  = 4;
    localparam int VW  = 2;
    localparam int VCR = 4;
    localparam int SCR = 8;
    localparam int DW  = 64;
    localparam int CW  = 1 + VW + 2 + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          inj_valid;
    logic          inj_ready;
    logic [VW-1:0] inj_vc;
    logic          inj_head;
    logic          inj_tail;
    logic [DW-1:0] inj_data;
    logic [CW-1:0] channel_out;
    logic          shared_vc_out;
    logic [VW:0]   flow_ctrl_in;
    logic          credit_for_shared_in;
    logic          idle;
    logic          error;

    always #5 clk = ~clk;

    nic_flit_tx dut (
        .clk                  (clk),
        .reset                (reset),
        .inj_valid            (inj_valid),
        .inj_ready            (inj_ready),
        .inj_vc               (inj_vc),
        .inj_head             (inj_head),
        .inj_tail             (inj_tail),
        .inj_data             (inj_data),
        .channel_out          (channel_out),
        .shared_vc_out        (shared_vc_out),
        .flow_ctrl_in         (flow_ctrl_in),
        .credit_for_shared_in (credit_for_shared_in),
        .idle                 (idle),
        .error                (error)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries are {channel, shared_flag}.
    logic [CW:0] sb [$];
    logic [CW:0] mon_exp;

    // Reference model state
    int m_priv [NV];
    int m_shr;
    bit m_err;
    bit m_open;
    int m_open_vc;

    // ------------------------------------------------------------------
    // Monitor: every flit must match the oldest prediction, one cycle
    // after acceptance; any valid flit without a prediction is an error.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                checks++;
                if ({channel_out, shared_vc_out} !== mon_exp) begin
                    failures++;
                    $display("FAIL scoreboard_flit: got ch=%h sh=%b, expected ch=%h sh=%b",
                             channel_out, shared_vc_out, mon_exp[CW:1], mon_exp[0]);
                end
            end else if (channel_out[CW-1] !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_flit: got ch=%h, expected valid=0", channel_out);
            end
        end
    end

    task automatic clear_inputs();
        inj_valid            = 1'b0;
        inj_vc               = '0;
        inj_head             = 1'b0;
        inj_tail             = 1'b0;
        inj_data             = '0;
        flow_ctrl_in         = '0;
        credit_for_shared_in = 1'b0;
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) m_priv[v] = VCR;
        m_shr     = SCR;
        m_err     = 1'b0;
        m_open    = 1'b0;
        m_open_vc = 0;
        sb.delete();
    endtask

    function automatic bit exp_ready();
        return (inj_valid == 1'b1) && (m_priv[int'(inj_vc)] != 0 || m_shr != 0);
    endfunction

    // Apply one cycle's stimulus, then let combinational ready settle.
    task automatic drive(input bit v, input int vc, input bit h, input bit t,
                         input logic [VW:0] fc, input bit cs);
        inj_valid            = v;
        inj_vc               = vc[VW-1:0];
        inj_head             = h;
        inj_tail             = t;
        inj_data             = {$urandom, $urandom};
        flow_ctrl_in         = fc;
        credit_for_shared_in = cs;
        #1;
    endtask

    // Clock edge: update the model from the inputs sampled at that edge,
    // predict any accepted flit, then drop the stimulus.
    task automatic tick();
        bit acc, sh, pc, pr, sr;
        int v, rv;
        @(posedge clk);
        v   = int'(inj_vc);
        acc = exp_ready();
        sh  = acc && (m_priv[v] == 0);
        pc  = acc && !sh;
        if (acc) sb.push_back({1'b1, inj_vc, inj_head, inj_tail, inj_data, sh});

        pr = flow_ctrl_in[VW];
        rv = int'(flow_ctrl_in[VW-1:0]);
        if (!(pr && pc && rv == v)) begin
            if (pr) begin
                if (m_priv[rv] == VCR) m_err = 1'b1;
                else m_priv[rv]++;
            end
            if (pc) m_priv[v]--;
        end

        sr = credit_for_shared_in;
        if (!(sr && sh)) begin
            if (sr) begin
                if (m_shr == SCR) m_err = 1'b1;
                else m_shr++;
            end
            if (sh) m_shr--;
        end

        if (acc) begin
            if (!m_open && !inj_head) m_err = 1'b1;
            if (m_open && (inj_head || v != m_open_vc)) m_err = 1'b1;
            if (inj_head) begin
                m_open    = !inj_tail;
                m_open_vc = v;
            end else if (inj_tail) begin
                m_open = 1'b0;
            end
        end
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (channel_out !== '0) begin
            failures++;
            $display("FAIL reset_channel: got %h, expected 0", channel_out);
        end
        checks++;
        if (shared_vc_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_shared: got %b, expected 0", shared_vc_out);
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL reset_error: got %b, expected 0", error);
        end
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got %b, expected 1", idle);
        end
        checks++;
        if (inj_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b, expected 0", inj_ready);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_private_first();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1, 1'b1, 1'b1, '0, 1'b0);
            checks++;
            if (inj_ready !== 1'b1) begin
                failures++;
                $display("FAIL priv_first_ready[%0d]: got %b, expected 1", i, inj_ready);
            end
            tick();
            checks++;
            if (shared_vc_out !== (i >= 4)) begin
                failures++;
                $display("FAIL priv_first_shared[%0d]: got %b, expected %b",
                         i, shared_vc_out, (i >= 4));
            end
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL priv_first_error: got %b, expected 0", error);
        end
    endtask

    task automatic test_exhaustion();
        bit exp;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2, 1'b1, 1'b1, '0, 1'b0);
            exp = (i < 10);
            checks++;
            if (inj_ready !== exp) begin
                failures++;
                $display("FAIL exhaust_ready[%0d]: got %b, expected %b", i, inj_ready, exp);
            end
            tick();
        end
        // Return cycle: the gate must stay closed until the next cycle.
        drive(1'b1, 2, 1'b1, 1'b1, '0, 1'b1);
        checks++;
        if (inj_ready !== 1'b0) begin
            failures++;
            $display("FAIL exhaust_no_bypass: got %b, expected 0", inj_ready);
        end
        tick();
        drive(1'b1, 2, 1'b1, 1'b1, '0, 1'b0);
        checks++;
        if (inj_ready !== 1'b1) begin
            failures++;
            $display("FAIL exhaust_after_return: got %b, expected 1", inj_ready);
        end
        tick();
        checks++;
        if (shared_vc_out !== 1'b1) begin
            failures++;
            $display("FAIL exhaust_shared_flag: got %b, expected 1", shared_vc_out);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 1'b1, 1'b1, '0, 1'b0);
            tick();
        end
        // priv[0] is now 1: consume and return VC0 together.
        drive(1'b1, 0, 1'b1, 1'b1, {1'b1, 2'd0}, 1'b0);
        checks++;
        if (inj_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_ready: got %b, expected 1", inj_ready);
        end
        tick();
        checks++;
        if (shared_vc_out !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL simul_flit: got sh=%b err=%b, expected sh=0 err=0", shared_vc_out, error);
        end
        // One private credit must remain, then the shared pool takes over.
        drive(1'b1, 0, 1'b1, 1'b1, '0, 1'b0);
        tick();
        checks++;
        if (shared_vc_out !== 1'b0) begin
            failures++;
            $display("FAIL simul_last_private: got %b, expected 0", shared_vc_out);
        end
        drive(1'b1, 0, 1'b1, 1'b1, '0, 1'b0);
        tick();
        checks++;
        if (shared_vc_out !== 1'b1) begin
            failures++;
            $display("FAIL simul_then_shared: got %b, expected 1", shared_vc_out);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1'b0, 0, 1'b0, 1'b0, {1'b1, 2'd3}, 1'b0);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL ovf_error_before: got %b, expected 0", error);
        end
        tick();
        checks++;
        if (error !== 1'b1 || idle !== 1'b1) begin
            failures++;
            $display("FAIL ovf_error_idle: got err=%b idle=%b, expected err=1 idle=1", error, idle);
        end
        // priv[3] must have saturated at 4: four private flits, then shared.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3, 1'b1, 1'b1, '0, 1'b0);
            tick();
            checks++;
            if (shared_vc_out !== (i == 4)) begin
                failures++;
                $display("FAIL ovf_saturate[%0d]: got %b, expected %b", i, shared_vc_out, (i == 4));
            end
        end
    endtask

    task automatic test_protocol();
        do_reset();
        drive(1'b1, 0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL proto_head_error: got %b, expected 0", error);
        end
        drive(1'b1, 2, 1'b0, 1'b0, '0, 1'b0);
        tick();
        checks++;
        if (error !== 1'b1 || channel_out[CW-1] !== 1'b1 || channel_out[CW-2 -: VW] !== 2'd2) begin
            failures++;
            $display("FAIL proto_vc_mismatch: got err=%b valid=%b vc=%0d, expected err=1 valid=1 vc=2",
                     error, channel_out[CW-1], channel_out[CW-2 -: VW]);
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1, (i == 0), (i == 2), '0, 1'b0);
            tick();
            checks++;
            if (channel_out[CW-1] !== 1'b1 || channel_out[DW+1] !== (i == 0) ||
                channel_out[DW] !== (i == 2)) begin
                failures++;
                $display("FAIL proto_burst[%0d]: got v=%b h=%b t=%b, expected v=1 h=%b t=%b",
                         i, channel_out[CW-1], channel_out[DW+1], channel_out[DW], (i == 0), (i == 2));
            end
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL proto_burst_error: got %b, expected 0", error);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 0, (i == 0), 1'b0, '0, 1'b0);
            checks++;
            if (inj_ready !== 1'b1) begin
                failures++;
                $display("FAIL midrst_fill_ready[%0d]: got %b, expected 1", i, inj_ready);
            end
            tick();
        end
        drive(1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (inj_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_depleted: got %b, expected 0", inj_ready);
        end
        // Mid-cycle assertion: outputs must clear without a clock edge.
        clear_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (channel_out !== '0 || shared_vc_out !== 1'b0 || error !== 1'b0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async: got ch=%h sh=%b err=%b idle=%b, expected 0/0/0/1",
                     channel_out, shared_vc_out, error, idle);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL midrst_idle: got %b, expected 1", idle);
        end
        drive(1'b1, 0, 1'b1, 1'b1, '0, 1'b0);
        checks++;
        if (inj_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready: got %b, expected 1", inj_ready);
        end
        tick();
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL midrst_error: got %b, expected 0", error);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_reset();
        test_reset();
        test_private_first();
        test_exhaustion();
        test_simultaneous();
        test_overflow();
        test_protocol();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nic_flit_tx.md
# nic_flit_tx

Node-side injection transmitter for one router input port. It accepts flits from the network interface and drives them onto the router's incoming channel in HEAD_TAIL format. It keeps per-VC private credit counters plus one shared-buffer credit pool, restoring credits from the router's `flow_ctrl_out_ip` and `credit_for_shared_out` returns. It is the sending end of the credit/shared-VC protocol that the router terminates, and it flags the shared-buffer usage of each flit on `shared_vc_out`.

## Interface
- `num_vcs`, 4, number of VCs on the link.
- `vc_idx_width`, clogb(num_vcs), VC index width.
- `vc_credits`, 4, private buffer slots per VC at the router input.
- `shared_credits`, 8, shared buffer slots at the router input.
- `flit_data_width`, 64, payload width.
- `channel_width`, 1+vc_idx_width+2+flit_data_width, packed channel width.
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inj_valid`  in  1  a flit is offered.
- `inj_ready`  out  1  the offered flit is accepted this cycle.
- `inj_vc`  in  vc_idx_width  target VC.
- `inj_head`  in  1  head flit.
- `inj_tail`  in  1  tail flit.
- `inj_data`  in  flit_data_width  payload.
- `channel_out`  out  channel_width  packed as {valid, vc, head, tail, data}, MSB first.
- `shared_vc_out`  out  1  the flit on `channel_out` consumed a shared credit.
- `flow_ctrl_in`  in  1+vc_idx_width  {credit_valid, credit_vc}: returns one private credit.
- `credit_for_shared_in`  in  1  returns one shared credit.
- `idle`  out  1  all counters are at their maximum and no packet is open.
- `error`  out  1  sticky protocol or credit error.

## Operation
- **Counters.**
  - `priv[v]` has width clogb(vc_credits+1) and resets to `vc_credits`.
  - `shr` has width clogb(shared_credits+1) and resets to `shared_credits`.
- **Acceptance (combinational).** `inj_ready` = `inj_valid` & (`priv[inj_vc]` != 0 | `shr` != 0). `inj_ready` never depends on the `channel_out` state.
- **Credit selection.** On accept:
  - If `priv[inj_vc]` != 0, decrement it and send with shared flag 0.
  - Otherwise decrement `shr` and send with shared flag 1.
  - Private credits are always preferred.
- **Returns.**
  - `flow_ctrl_in` valid increments `priv[credit_vc]`.
  - `credit_for_shared_in` increments `shr`.
  - Consume and return on the same counter in the same cycle leaves it unchanged.
  - A private return and a shared return in the same cycle are independent.
- **Overflow.** A return to a counter already at its maximum (with no same-cycle consume) sets `error`. The counter saturates and holds at the maximum.
- **Packet FSM**, states IDLE and OPEN, with a registered `open_vc`:
  - IDLE, accepted head without tail -> OPEN, and latch `open_vc`.
  - IDLE, accepted head+tail -> IDLE.
  - OPEN, accepted tail -> IDLE.
  - Accepted non-head in IDLE -> set `error`.
  - Accepted head in OPEN -> set `error`.
  - `inj_vc` != `open_vc` in OPEN -> set `error`.
  - On every error case the flit is still transmitted and the FSM follows the head/tail bits.
- **Errors.** `error` is sticky and clears only on reset.
- **Idle.** `idle` = FSM in IDLE, all `priv` equal `vc_credits`, and `shr` equals `shared_credits`.

## Timing
- **Reset values.** `channel_out` = 0, `shared_vc_out` = 0, `error` = 0, `idle` = 1, FSM in IDLE, counters at their maxima. Reset asserted mid-packet discards the open packet and any in-flight counter state immediately.
- **Output latency.** `channel_out` and `shared_vc_out` are registered: a flit accepted in cycle N appears in cycle N+1 for exactly one cycle. In cycles with no accept, the valid bit is 0 and the other fields are don't-care (driven 0).
- **Throughput.** Back-to-back accepts give one flit per cycle.
- **Credit visibility.** A credit returned in cycle N affects `inj_ready` from cycle N+1; there is no combinational bypass from return to ready.
- **Counter arithmetic.** A decrement at 0 cannot occur because ready is gated. An increment at the maximum saturates and raises the error.

## Test plan
- **Private credits first.** Reset, then inject 6 single-flit packets on VC1 with no returns. Flits 1-4 go out with `shared_vc_out`=0 and flits 5-6 with `shared_vc_out`=1. `priv[1]`=0 and `shr`=6.
- **Exhaustion.** Keep injecting on VC2 with no returns. `inj_ready` drops after 4+6=10 accepts. One `credit_for_shared_in` pulse raises `inj_ready` the next cycle, and the resulting flit has `shared_vc_out`=1.
- **Simultaneous consume and return.** With `priv[0]`=1, accept a VC0 flit in the same cycle as a VC0 credit return. `priv[0]` stays 1 and `error` stays 0.
- **Overflow.** From reset, pulse `flow_ctrl_in` with VC3. `error`=1 from the next cycle, `priv[3]` stays 4, and `idle` remains 1.
- **Packet protocol.** Send head (VC0), then body with `inj_vc`=2. `error` is set and the body flit still appears on `channel_out` with vc=2. Separately, a 3-flit packet sent at full rate has valid asserted in 3 consecutive cycles with head then tail bits correct.
- **Reset mid-packet.** Assert `reset` while in OPEN with credits depleted. All outputs reach their reset values asynchronously. After release, a head flit is accepted without error and `idle`=1 before injection.
